// File: rtl/rat_mp.sv
// rat_mp: multi-port register alias table for the out-of-order core.
// Renames up to RENAME_W instructions per cycle, keeping a speculative
// file (busy/tag/spec) and a committed architectural file (arf).
// Optional feature macro: RAT_WB_BYPASS_EN forwards same-cycle
// writeback results into the rename lookup.
module rat_mp #(
  parameter int unsigned NREG     = 32,
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ROBID_W  = 8,
  parameter int unsigned RENAME_W = 2,
  parameter int unsigned WB_W     = 2,
  parameter int unsigned RET_W    = 2,
  localparam int unsigned REG_W   = $clog2(NREG)
) (
  input  logic                        clk,
  input  logic                        rst,
  // rename request
  input  logic [RENAME_W-1:0]         rename_valid,
  input  logic [RENAME_W-1:0]         rename_rd_en,
  input  logic [RENAME_W*REG_W-1:0]   rename_rd,
  input  logic [RENAME_W*ROBID_W-1:0] rename_robid,
  input  logic [RENAME_W*REG_W-1:0]   rename_rs1,
  input  logic [RENAME_W*REG_W-1:0]   rename_rs2,
  // rename lookup result
  output logic [RENAME_W-1:0]         rat_rs1_valid,
  output logic [RENAME_W-1:0]         rat_rs2_valid,
  output logic [RENAME_W*XLEN-1:0]    rat_rs1_tagval,
  output logic [RENAME_W*XLEN-1:0]    rat_rs2_tagval,
  // writeback
  input  logic [WB_W-1:0]             wb_valid,
  input  logic [WB_W-1:0]             wb_error,
  input  logic [WB_W*ROBID_W-1:0]     wb_robid,
  input  logic [WB_W*REG_W-1:0]       wb_rd,
  input  logic [WB_W*XLEN-1:0]        wb_result,
  // ROB flush / retire
  input  logic                        rob_flush,
  input  logic [RET_W-1:0]            rob_ret_valid,
  input  logic [RET_W*ROBID_W-1:0]    rob_ret_robid,
  input  logic [RET_W*REG_W-1:0]      rob_ret_rd,
  input  logic [RET_W*XLEN-1:0]       rob_ret_result
);

  // Table state
  logic [NREG-1:0]    busy_q, busy_d;
  logic [ROBID_W-1:0] tag_q  [NREG];
  logic [ROBID_W-1:0] tag_d  [NREG];
  logic [XLEN-1:0]    spec_q [NREG];
  logic [XLEN-1:0]    spec_d [NREG];
  logic [XLEN-1:0]    arf_q  [NREG];
  logic [XLEN-1:0]    arf_d  [NREG];

  // Writeback rd and retire robid are carried for the ROB's benefit only;
  // the table matches writebacks by tag and retires by rd.
  logic unused_sink;
  assign unused_sink = ^{wb_rd, rob_ret_robid};

  // Resolve one source operand for rename slot `slot`; returns {valid, tagval}.
  function automatic logic [XLEN:0] lookup(input int unsigned slot,
                                           input logic [REG_W-1:0] src);
    logic               dep_hit;
    logic [ROBID_W-1:0] dep_tag;
    logic               vld;
    logic [XLEN-1:0]    tv;
    dep_hit = 1'b0;
    dep_tag = '0;
    vld     = 1'b0;
    tv      = '0;
    // Youngest older slot in the same group that writes src
    for (int unsigned j = 0; j < RENAME_W; j++) begin
      if (j < slot && rename_valid[j] && rename_rd_en[j] &&
          rename_rd[j*REG_W +: REG_W] == src) begin
        dep_hit = 1'b1;
        dep_tag = rename_robid[j*ROBID_W +: ROBID_W];
      end
    end
    if (src == '0) begin
      vld = 1'b1;
      tv  = '0;
    end else if (dep_hit) begin
      vld = 1'b0;
      tv  = XLEN'(dep_tag);
    end else if (!busy_q[src]) begin
      vld = 1'b1;
      tv  = spec_q[src];
    end else begin
      vld = 1'b0;
      tv  = XLEN'(tag_q[src]);
`ifdef RAT_WB_BYPASS_EN
      for (int unsigned p = 0; p < WB_W; p++) begin
        if (wb_valid[p] && !wb_error[p] &&
            wb_robid[p*ROBID_W +: ROBID_W] == tag_q[src]) begin
          vld = 1'b1;
          tv  = wb_result[p*XLEN +: XLEN];
        end
      end
`endif
    end
    return {vld, tv};
  endfunction

  // Combinational operand lookup for every slot; forced ready/zero in reset
  always_comb begin
    logic [XLEN:0] r1;
    logic [XLEN:0] r2;
    rat_rs1_valid  = '1;
    rat_rs2_valid  = '1;
    rat_rs1_tagval = '0;
    rat_rs2_tagval = '0;
    r1             = '0;
    r2             = '0;
    if (!rst) begin
      for (int unsigned i = 0; i < RENAME_W; i++) begin
        r1 = lookup(i, rename_rs1[i*REG_W +: REG_W]);
        r2 = lookup(i, rename_rs2[i*REG_W +: REG_W]);
        rat_rs1_valid[i]               = r1[XLEN];
        rat_rs1_tagval[i*XLEN +: XLEN] = r1[XLEN-1:0];
        rat_rs2_valid[i]               = r2[XLEN];
        rat_rs2_tagval[i*XLEN +: XLEN] = r2[XLEN-1:0];
      end
    end
  end

  // Next-state: retire into arf, then either flush-restore or wb + rename
  always_comb begin
    busy_d = busy_q;
    tag_d  = tag_q;
    spec_d = spec_q;
    arf_d  = arf_q;

    // Retire; later ports override earlier ones on the same rd
    for (int unsigned p = 0; p < RET_W; p++) begin
      if (rob_ret_valid[p] && rob_ret_rd[p*REG_W +: REG_W] != '0) begin
        arf_d[rob_ret_rd[p*REG_W +: REG_W]] = rob_ret_result[p*XLEN +: XLEN];
      end
    end

    if (rob_flush) begin
      // Squash everything speculative; restore from the just-updated arf
      for (int unsigned r = 0; r < NREG; r++) begin
        busy_d[r] = 1'b0;
        spec_d[r] = arf_d[r];
      end
    end else begin
      // Writeback clears busy on a tag match against the current table
      for (int unsigned p = 0; p < WB_W; p++) begin
        if (wb_valid[p] && !wb_error[p]) begin
          for (int unsigned r = 0; r < NREG; r++) begin
            if (busy_q[r] && tag_q[r] == wb_robid[p*ROBID_W +: ROBID_W]) begin
              spec_d[r] = wb_result[p*XLEN +: XLEN];
              busy_d[r] = 1'b0;
            end
          end
        end
      end
      // Rename applied after wb so a new mapping wins; higher slot wins
      for (int unsigned i = 0; i < RENAME_W; i++) begin
        if (rename_valid[i] && rename_rd_en[i] &&
            rename_rd[i*REG_W +: REG_W] != '0) begin
          busy_d[rename_rd[i*REG_W +: REG_W]] = 1'b1;
          tag_d[rename_rd[i*REG_W +: REG_W]]  = rename_robid[i*ROBID_W +: ROBID_W];
        end
      end
    end

    // x0 is hardwired
    busy_d[0] = 1'b0;
    spec_d[0] = '0;
    arf_d[0]  = '0;
  end

  // Table registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      for (int unsigned r = 0; r < NREG; r++) begin
        tag_q[r]  <= '0;
        spec_q[r] <= '0;
        arf_q[r]  <= '0;
      end
    end else begin
      busy_q <= busy_d;
      for (int unsigned r = 0; r < NREG; r++) begin
        tag_q[r]  <= tag_d[r];
        spec_q[r] <= spec_d[r];
        arf_q[r]  <= arf_d[r];
      end
    end
  end

endmodule

// File: tb/tb_rat_mp.sv
// tb_rat_mp: directed scoreboard bench for rat_mp. Stimulus pushes expected
// lookup results into a queue; a negedge monitor pops and compares them.
module tb_rat_mp;

  localparam int unsigned NREG     = 32;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned ROBID_W  = 8;
  localparam int unsigned RENAME_W = 2;
  localparam int unsigned WB_W     = 2;
  localparam int unsigned RET_W    = 2;
  localparam int unsigned REG_W    = 5;

  logic                        clk;
  logic                        rst;
  logic [RENAME_W-1:0]         rename_valid;
  logic [RENAME_W-1:0]         rename_rd_en;
  logic [RENAME_W*REG_W-1:0]   rename_rd;
  logic [RENAME_W*ROBID_W-1:0] rename_robid;
  logic [RENAME_W*REG_W-1:0]   rename_rs1;
  logic [RENAME_W*REG_W-1:0]   rename_rs2;
  logic [RENAME_W-1:0]         rat_rs1_valid;
  logic [RENAME_W-1:0]         rat_rs2_valid;
  logic [RENAME_W*XLEN-1:0]    rat_rs1_tagval;
  logic [RENAME_W*XLEN-1:0]    rat_rs2_tagval;
  logic [WB_W-1:0]             wb_valid;
  logic [WB_W-1:0]             wb_error;
  logic [WB_W*ROBID_W-1:0]     wb_robid;
  logic [WB_W*REG_W-1:0]       wb_rd;
  logic [WB_W*XLEN-1:0]        wb_result;
  logic                        rob_flush;
  logic [RET_W-1:0]            rob_ret_valid;
  logic [RET_W*ROBID_W-1:0]    rob_ret_robid;
  logic [RET_W*REG_W-1:0]      rob_ret_rd;
  logic [RET_W*XLEN-1:0]       rob_ret_result;

  rat_mp #(
    .NREG(NREG), .XLEN(XLEN), .ROBID_W(ROBID_W),
    .RENAME_W(RENAME_W), .WB_W(WB_W), .RET_W(RET_W)
  ) dut (
    .clk(clk), .rst(rst),
    .rename_valid(rename_valid), .rename_rd_en(rename_rd_en),
    .rename_rd(rename_rd), .rename_robid(rename_robid),
    .rename_rs1(rename_rs1), .rename_rs2(rename_rs2),
    .rat_rs1_valid(rat_rs1_valid), .rat_rs2_valid(rat_rs2_valid),
    .rat_rs1_tagval(rat_rs1_tagval), .rat_rs2_tagval(rat_rs2_tagval),
    .wb_valid(wb_valid), .wb_error(wb_error), .wb_robid(wb_robid),
    .wb_rd(wb_rd), .wb_result(wb_result),
    .rob_flush(rob_flush), .rob_ret_valid(rob_ret_valid),
    .rob_ret_robid(rob_ret_robid), .rob_ret_rd(rob_ret_rd),
    .rob_ret_result(rob_ret_result)
  );

  typedef struct {
    string       nm;
    int          slot;
    bit          src2;
    bit          vld;
    logic [31:0] tv;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clr();
    rename_valid   = '0;
    rename_rd_en   = '0;
    rename_rd      = '0;
    rename_robid   = '0;
    rename_rs1     = '0;
    rename_rs2     = '0;
    wb_valid       = '0;
    wb_error       = '0;
    wb_robid       = '0;
    wb_rd          = '0;
    wb_result      = '0;
    rob_flush      = 1'b0;
    rob_ret_valid  = '0;
    rob_ret_robid  = '0;
    rob_ret_rd     = '0;
    rob_ret_result = '0;
  endtask

  task automatic ren(input int s, input bit rd_en, input int rd, input int robid,
                     input int rs1, input int rs2);
    rename_valid[s]                    = 1'b1;
    rename_rd_en[s]                    = rd_en;
    rename_rd[s*REG_W +: REG_W]        = REG_W'(rd);
    rename_robid[s*ROBID_W +: ROBID_W] = ROBID_W'(robid);
    rename_rs1[s*REG_W +: REG_W]       = REG_W'(rs1);
    rename_rs2[s*REG_W +: REG_W]       = REG_W'(rs2);
  endtask

  task automatic wb(input int p, input bit err, input int robid, input int rd,
                    input logic [31:0] res);
    wb_valid[p]                    = 1'b1;
    wb_error[p]                    = err;
    wb_robid[p*ROBID_W +: ROBID_W] = ROBID_W'(robid);
    wb_rd[p*REG_W +: REG_W]        = REG_W'(rd);
    wb_result[p*XLEN +: XLEN]      = res;
  endtask

  task automatic ret(input int p, input int rd, input logic [31:0] res);
    rob_ret_valid[p]                    = 1'b1;
    rob_ret_robid[p*ROBID_W +: ROBID_W] = '0;
    rob_ret_rd[p*REG_W +: REG_W]        = REG_W'(rd);
    rob_ret_result[p*XLEN +: XLEN]      = res;
  endtask

  task automatic expect_op(input string nm, input int slot, input bit src2,
                           input bit vld, input logic [31:0] tv);
    exp_t e;
    e.nm = nm; e.slot = slot; e.src2 = src2; e.vld = vld; e.tv = tv;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: lookup outputs are always presented; compare away from posedge
  always @(negedge clk) begin
    exp_t        e;
    logic        gv;
    logic [31:0] gt;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      gv = e.src2 ? rat_rs2_valid[e.slot] : rat_rs1_valid[e.slot];
      gt = e.src2 ? rat_rs2_tagval[e.slot*XLEN +: XLEN]
                  : rat_rs1_tagval[e.slot*XLEN +: XLEN];
      n_cmp++;
      if (gv !== e.vld || gt !== e.tv) begin
        n_bad++;
        $display("FAIL %s slot%0d rs%0d: got valid=%0b tagval=%08h, expected valid=%0b tagval=%08h",
                 e.nm, e.slot, e.src2 ? 2 : 1, gv, gt, e.vld, e.tv);
      end
    end
  end

  initial begin
    // Reset: outputs forced ready/zero even with an in-group dependency
    clr();
    rst = 1'b1;
    ren(0, 1, 5, 'h12, 0, 0);
    ren(1, 0, 0, 0, 5, 5);
    expect_op("rst_s0", 0, 0, 1'b1, 32'h0);
    expect_op("rst_s1a", 1, 0, 1'b1, 32'h0);
    expect_op("rst_s1b", 1, 1, 1'b1, 32'h0);
    cyc();
    rst = 1'b0;

    // Basic rename / wb / read-back of value
    clr(); ren(0, 1, 5, 'h12, 0, 0);
    expect_op("rs_zero", 0, 0, 1'b1, 32'h0);
    cyc();
    clr(); ren(0, 0, 0, 0, 5, 0);
    expect_op("busy_tag", 0, 0, 1'b0, 32'h12);
    cyc();
    clr(); wb(0, 0, 'h12, 5, 32'hDEADBEEF);
    cyc();
    clr(); ren(0, 0, 0, 0, 5, 0); ren(1, 0, 0, 0, 0, 5);
    expect_op("wb_val_s0", 0, 0, 1'b1, 32'hDEADBEEF);
    expect_op("wb_val_s1", 1, 1, 1'b1, 32'hDEADBEEF);
    cyc();

    // Intra-group dependency and same-rd priority
    clr(); ren(0, 1, 3, 'h20, 3, 0); ren(1, 0, 0, 0, 3, 0);
    expect_op("intra_dep", 1, 0, 1'b0, 32'h20);
    expect_op("intra_self", 0, 0, 1'b1, 32'h0);
    cyc();
    clr(); ren(0, 1, 7, 'h21, 0, 0); ren(1, 1, 7, 'h22, 0, 7);
    expect_op("intra_dep7", 1, 1, 1'b0, 32'h21);
    cyc();
    clr(); ren(0, 0, 0, 0, 7, 0); ren(1, 0, 0, 0, 3, 0);
    expect_op("same_rd_hi", 0, 0, 1'b0, 32'h22);
    expect_op("tag3", 1, 0, 1'b0, 32'h20);
    cyc();

    // Same-cycle writeback vs. lookup
    clr(); ren(0, 1, 4, 'h30, 0, 0);
    cyc();
    clr(); ren(0, 0, 0, 0, 4, 0); wb(1, 0, 'h30, 4, 32'h12345678);
`ifdef RAT_WB_BYPASS_EN
    expect_op("bypass", 0, 0, 1'b1, 32'h12345678);
`else
    expect_op("no_bypass", 0, 0, 1'b0, 32'h30);
`endif
    cyc();
    clr(); ren(0, 0, 0, 0, 4, 0);
    expect_op("after_wb4", 0, 0, 1'b1, 32'h12345678);
    cyc();

    // Retire, speculate over it, then flush back to committed
    clr(); ret(0, 6, 32'h55);
    cyc();
    clr(); ren(0, 1, 6, 'h40, 0, 0);
    cyc();
    clr(); wb(0, 0, 'h40, 6, 32'h99);
    cyc();
    clr(); ren(0, 0, 0, 0, 6, 0);
    expect_op("spec6", 0, 0, 1'b1, 32'h99);
    cyc();
    clr(); rob_flush = 1'b1;
    cyc();
    clr(); ren(0, 0, 0, 0, 6, 5); ren(1, 0, 0, 0, 3, 7);
    expect_op("flush6", 0, 0, 1'b1, 32'h55);
    expect_op("flush5", 0, 1, 1'b1, 32'h0);
    expect_op("flush3", 1, 0, 1'b1, 32'h0);
    expect_op("flush7", 1, 1, 1'b1, 32'h0);
    cyc();

    // Flush with concurrent rename and retire of the same rd
    clr(); rob_flush = 1'b1; ren(0, 1, 9, 'h50, 0, 0); ret(0, 9, 32'h77);
    cyc();
    clr(); ren(0, 0, 0, 0, 9, 0);
    expect_op("flush_ret9", 0, 0, 1'b1, 32'h77);
    cyc();

    // Two retire ports on the same rd: higher port wins
    clr(); rob_flush = 1'b1; ret(0, 11, 32'hAA); ret(1, 11, 32'hBB);
    cyc();
    clr(); ren(1, 0, 0, 0, 11, 9);
    expect_op("ret_hi11", 1, 0, 1'b1, 32'hBB);
    expect_op("keep9", 1, 1, 1'b1, 32'h77);
    cyc();

    // Error writeback ignored; rd = 0 rename has no effect
    clr(); ren(0, 1, 10, 'h60, 0, 0);
    cyc();
    clr(); wb(0, 1, 'h60, 10, 32'hBAD); ren(0, 1, 0, 'h61, 0, 0); ren(1, 0, 0, 0, 0, 0);
    expect_op("rd0_nodep", 1, 0, 1'b1, 32'h0);
    cyc();
    clr(); ren(0, 0, 0, 0, 10, 0); ren(1, 0, 0, 0, 0, 0);
    expect_op("wb_err", 0, 0, 1'b0, 32'h60);
    expect_op("reg0", 1, 0, 1'b1, 32'h0);
    cyc();

    // Both writeback ports in one cycle
    clr(); ren(0, 1, 12, 'h70, 0, 0); ren(1, 1, 13, 'h71, 0, 0);
    cyc();
    clr(); wb(0, 0, 'h70, 12, 32'h12); wb(1, 0, 'h71, 13, 32'h13);
    cyc();
    clr(); ren(0, 0, 0, 0, 12, 0); ren(1, 0, 0, 0, 0, 13);
    expect_op("wb_p0", 0, 0, 1'b1, 32'h12);
    expect_op("wb_p1", 1, 1, 1'b1, 32'h13);
    cyc();

    // Rename in the same cycle as the old tag's writeback keeps it busy
    clr(); ren(0, 1, 14, 'h80, 0, 0);
    cyc();
    clr(); wb(0, 0, 'h80, 14, 32'h5); ren(0, 1, 14, 'h81, 0, 0);
    cyc();
    clr(); ren(0, 0, 0, 0, 14, 0);
    expect_op("ren_over_wb", 0, 0, 1'b0, 32'h81);
    cyc();
    clr();

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
